dca_matrix_row_loader: RTL
==========================

Name: dca_matrix_row_loader

Overview:
- Matrix row load stage directly upstream of the matrix MAC datapath.
- Takes one load command (base address, row stride, row count, beats per row) and issues one SLX read burst per row on its memory port.
- Buffers the returned read data in a small FIFO and presents it as a valid/ready row-beat stream for the MAC operand path.
- One instance is planned per operand port (ma/mb).

Parameters:
BW_ADDR, 32, address width of SLX port and command address/stride
BW_DATA, 128, SLX read data width and row-beat width
BW_NUM_ROW, 8, width of row-count field
FIFO_DEPTH, 4, read-data buffer depth in beats (power of 2, >=2)

Ports:
clk  in  1  core clock
rstnn  in  1  reset; asynchronous, active-high (asserted = 1)
cmd_valid  in  1  load command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_addr  in  BW_ADDR  base byte address of row 0
cmd_stride  in  BW_ADDR  byte distance between consecutive rows
cmd_num_row  in  BW_NUM_ROW  rows to load (0 allowed)
cmd_row_beats  in  8  beats per row minus 1 (drives slxqlen)
slxqvalid  out  1  read request valid
slxqdready  in  2  bit0: request accepted; bit1 unused
slxqlast  out  1  constant 1
slxqwrite  out  1  constant 0
slxqlen  out  8  burst length minus 1 (latched cmd_row_beats)
slxqsize  out  3  log2(BW_DATA/8)
slxqburst  out  2  constant 2'b01 (INCR)
slxqwstrb  out  BW_DATA/8  constant 0
slxqwdata  out  BW_DATA  constant 0
slxqaddr  out  BW_ADDR  row request address
slxydready  out  2  bit0: read data ready; bit1: write reply ready (constant 1)
slxyvalid  in  1  response valid
slxylast  in  1  last beat of burst
slxyresp  in  2  response code, nonzero = error
slxyrdata  in  BW_DATA  read data
row_valid  out  1  row beat valid
row_ready  in  1  consumer ready
row_data  out  BW_DATA  row beat
row_last  out  1  last beat of final row
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
error  out  1  sticky error flag
stall_cycles  out  32  back-pressure cycle count (see Optional Feature)

Behaviour:
- Reset values: all outputs 0 except slxqlast=1, slxqburst=2'b01, slxqsize per formula, slxydready[1]=1. FIFO is emptied, FSM goes to IDLE, counters are cleared. Reset mid-operation abandons the command; no further requests are issued.
- Clock and reset: single clock clk; rstnn asynchronous, active-high.
- FSM states: IDLE, REQ, DATA, DONE.
- IDLE: cmd_ready=1.
  - On accept, latch addr, stride, num_row, row_beats; clear error and row_idx.
  - num_row==0 -> DONE; otherwise -> REQ.
- REQ: slxqvalid=1, slxqaddr=current address. On slxqdready[0] -> DATA. slxqvalid stays high until accepted.
- DATA:
  - slxydready[0] = FIFO not full, combinational from registered FIFO count.
  - A beat is written when slxyvalid&&slxydready[0]; beat_cnt increments.
  - On the accepted beat with slxylast:
    - if beat_cnt != row_beats, set error;
    - if slxyresp != 0 on any beat, set error (data is still pushed);
    - if row_idx==num_row-1 -> DONE; else address += stride (modulo 2^BW_ADDR, wrap silent), row_idx++, -> REQ.
- DONE: wait until the FIFO is empty, then pulse done for one cycle -> IDLE. busy=1 in REQ/DATA/DONE.
- Only one burst is outstanding at a time.
- FIFO:
  - Output is first-word-fall-through: row_valid = not empty; a pop occurs on row_valid&&row_ready.
  - Simultaneous push and pop when full is not possible (ready is deasserted on full). Simultaneous push and pop at other occupancies leaves the count unchanged.
  - row_last is tagged at push time on the final beat of the final row.
- Latency: first request one cycle after command accept. A response beat appears on row_data the cycle after it is accepted.

Optional Feature:
- Macro: DCA_MATRIX_ROW_LOADER_PERF_EN.
- Enabled: stall_cycles increments (saturating at 2^32-1) on every cycle with row_valid&&!row_ready; it clears on command accept.
- Disabled: stall_cycles tied to 0 and the counter logic is absent.

Test Plan:
- addr=0x1000, stride=0x40, num_row=3, row_beats=3, always-ready memory and consumer -> requests at 0x1000, 0x1040, 0x1080 with len=3; 12 beats out in order; row_last only on beat 12; single done pulse; error=0.
- Same command with row_ready=0 for 20 cycles -> FIFO fills to 4, slxydready[0]=0, no data lost; with PERF_EN, stall_cycles=20 (20 stalled cycles after the FIFO becomes non-empty).
- num_row=0 -> no slxqvalid; done pulses two cycles after accept; busy high for exactly those cycles.
- slxyresp=2'b10 on beat 2 of row 1 -> all beats delivered, error=1 after done; next command accept clears error.
- addr=0xFFFF_FFC0, stride=0x40, num_row=2 -> second request address 0x0000_0000 (wrap); slxylast early at beat 1 with row_beats=3 -> error=1.
- Assert rstnn during DATA with 2 beats in the FIFO -> row_valid=0 and slxqvalid=0 immediately; after release, cmd_ready=1 and a new command runs cleanly.

Source files
------------

// File: rtl/dca_matrix_row_loader.sv
// dca_matrix_row_loader
// Matrix row load stage that sits just upstream of the MAC operand path.
// It accepts one load command: a base address, a row stride, a row count and
// the number of beats per row. For each row it issues one SLX read burst and
// waits for that burst to finish before it issues the next one. The returned
// beats pass through a small first-word-fall-through FIFO and leave as a
// valid/ready row-beat stream.
//
// Ports
//   clk, rstnn          core clock; asynchronous active-high reset
//   cmd_*               load command handshake and fields
//   slxq*               SLX request channel (reads only, one burst per row)
//   slxy*, slxydready   SLX response channel
//   row_*               row-beat stream toward the MAC operand path
//   busy, done, error   command status (done is a one-cycle pulse, error is sticky)
//   stall_cycles        count of consumer back-pressure cycles
//
// Optional feature macro: DCA_MATRIX_ROW_LOADER_PERF_EN
//   When defined, stall_cycles counts cycles with row_valid && !row_ready.
//   The count saturates and is cleared when a command is accepted.
//   When undefined, stall_cycles is tied to zero.
module dca_matrix_row_loader #(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 128,
  parameter int BW_NUM_ROW = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [BW_ADDR-1:0]     cmd_addr,
  input  logic [BW_ADDR-1:0]     cmd_stride,
  input  logic [BW_NUM_ROW-1:0]  cmd_num_row,
  input  logic [7:0]             cmd_row_beats,
  output logic                   slxqvalid,
  input  logic [1:0]             slxqdready,
  output logic                   slxqlast,
  output logic                   slxqwrite,
  output logic [7:0]             slxqlen,
  output logic [2:0]             slxqsize,
  output logic [1:0]             slxqburst,
  output logic [BW_DATA/8-1:0]   slxqwstrb,
  output logic [BW_DATA-1:0]     slxqwdata,
  output logic [BW_ADDR-1:0]     slxqaddr,
  output logic [1:0]             slxydready,
  input  logic                   slxyvalid,
  input  logic                   slxylast,
  input  logic [1:0]             slxyresp,
  input  logic [BW_DATA-1:0]     slxyrdata,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [BW_DATA-1:0]     row_data,
  output logic                   row_last,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            stall_cycles
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BW_NUM_ROW-1:0] ONE_ROW = BW_NUM_ROW'(1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_e;

  state_e                 state_q, state_d;
  logic [BW_ADDR-1:0]     addr_q, addr_d;
  logic [BW_ADDR-1:0]     stride_q, stride_d;
  logic [BW_NUM_ROW-1:0]  num_row_q, num_row_d;
  logic [BW_NUM_ROW-1:0]  row_idx_q, row_idx_d;
  logic [7:0]             row_beats_q, row_beats_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic                   error_q, error_d;
  logic                   done_q, done_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Each FIFO entry holds {row_last tag, data}.
  logic [BW_DATA:0]       fifo_mem [FIFO_DEPTH];

  logic accept, push, pop, fifo_full, fifo_empty, last_row;
  logic unused_inputs;

  assign unused_inputs = slxqdready[1];

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign last_row   = (row_idx_q == (num_row_q - ONE_ROW));

  // cmd_ready is held low while reset is asserted, so that every output
  // reads zero during reset and not only after it.
  assign cmd_ready = (state_q == IDLE) && !rstnn;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = slxyvalid && slxydready[0];
  assign pop       = row_valid && row_ready;

  // Fixed fields of the read-only SLX request.
  assign slxqvalid  = (state_q == REQ);
  assign slxqlast   = 1'b1;
  assign slxqwrite  = 1'b0;
  assign slxqlen    = row_beats_q;
  assign slxqsize   = 3'($clog2(BW_DATA/8));
  assign slxqburst  = 2'b01;
  assign slxqwstrb  = '0;
  assign slxqwdata  = '0;
  assign slxqaddr   = addr_q;
  assign slxydready = {1'b1, (state_q == DATA) && !fifo_full};

  assign row_valid = !fifo_empty;
  assign row_data  = row_valid ? fifo_mem[rptr_q][BW_DATA-1:0] : '0;
  assign row_last  = row_valid && fifo_mem[rptr_q][BW_DATA];

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign error = error_q;

  // Command sequencing. The machine keeps one burst in flight: it requests a
  // row, collects that row's beats, then advances the address and requests
  // the next row. A wrong burst length or an error response sets error, but
  // the beats are still delivered. done fires only after the FIFO has drained.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    num_row_d   = num_row_q;
    row_idx_d   = row_idx_q;
    row_beats_d = row_beats_q;
    beat_cnt_d  = beat_cnt_q;
    error_d     = error_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = cmd_addr;
          stride_d    = cmd_stride;
          num_row_d   = cmd_num_row;
          row_beats_d = cmd_row_beats;
          row_idx_d   = '0;
          beat_cnt_d  = '0;
          error_d     = 1'b0;
          state_d     = (cmd_num_row == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (slxqdready[0]) state_d = DATA;
      end
      DATA: begin
        if (push) begin
          if (slxyresp != 2'b00) error_d = 1'b1;
          if (slxylast) begin
            if (beat_cnt_q != row_beats_q) error_d = 1'b1;
            beat_cnt_d = '0;
            if (last_row) begin
              state_d = DONE;
            end else begin
              addr_d    = addr_q + stride_q;
              row_idx_d = row_idx_q + ONE_ROW;
              state_d   = REQ;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      DONE: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update. A push and a pop in the same cycle
  // leave the occupancy unchanged.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // State registers. Reset abandons any command that is in progress.
  always_ff @(posedge clk or posedge rstnn) begin
    if (rstnn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      num_row_q   <= '0;
      row_idx_q   <= '0;
      row_beats_q <= '0;
      beat_cnt_q  <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      num_row_q   <= num_row_d;
      row_idx_q   <= row_idx_d;
      row_beats_q <= row_beats_d;
      beat_cnt_q  <= beat_cnt_d;
      error_q     <= error_d;
      done_q      <= done_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage has no reset because occupancy decides what is valid. The
  // row_last tag is set only on the final beat of the final row.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= {slxylast && last_row, slxyrdata};
  end

`ifdef DCA_MATRIX_ROW_LOADER_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Back-pressure counter. It saturates at all ones, and a command accept
  // takes priority and clears it.
  always_comb begin
    stall_d = stall_q;
    if (accept)                                      stall_d = '0;
    else if (row_valid && !row_ready && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rstnn) begin
    if (rstnn) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
